// File: rtl/instr_issue_sequencer_if.sv
// Fetch/memory/PC bundle for the instruction issue sequencer.
// The sequencer takes the slave side; fetch, memory and the PC unit take the master side.
interface instr_issue_sequencer_if #(
    parameter int RCNT_W = 16
);
    logic              instr_valid;
    logic [7:0]        instr;
    logic              instr_ready;
    logic              branch_cond;
    logic              mem_req;
    logic              mem_we;
    logic [4:0]        mem_addr;
    logic              mem_ack;
    logic              pc_load;
    logic [4:0]        pc_target;
    logic              retire;
    logic [2:0]        retire_class;
    logic              illegal_err;
    logic              err_clr;
    logic [RCNT_W-1:0] retire_cnt;

    modport master (
        output instr_valid, instr, branch_cond, mem_ack, err_clr,
        input  instr_ready, mem_req, mem_we, mem_addr, pc_load, pc_target,
               retire, retire_class, illegal_err, retire_cnt
    );

    modport slave (
        input  instr_valid, instr, branch_cond, mem_ack, err_clr,
        output instr_ready, mem_req, mem_we, mem_addr, pc_load, pc_target,
               retire, retire_class, illegal_err, retire_cnt
    );
endinterface

// File: rtl/instr_issue_sequencer.sv
// Issues one 8-bit instruction at a time to the memory port, the PC unit or the
// misc-execution path, and retires it only after that resource has completed.
module instr_issue_sequencer #(
    parameter int TIMEOUT      = 15,
    parameter int FLUSH_CYCLES = 2,
    parameter int RCNT_W       = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    instr_issue_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_MEM, S_RET, S_FLUSH, S_ERR} state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES);

    // Returns {illegal, class}. Classes 0..3 come from instr[6:5] when instr[7]=0,
    // classes 4..7 from instr[1:0] when instr[2]=0; the top-bits test has priority.
    function automatic logic [3:0] decode(input logic [7:0] i);
        if (!i[7])
            decode = {2'b00, i[6:5]};
        else if (!i[2])
            decode = {2'b01, i[1:0]};
        else
            decode = 4'b1000;
    endfunction

    function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    state_t            state, state_n;
    logic [3:0]        dec;
    logic              accept;
    logic [4:0]        addr_p1;
    logic [2:0]        cls_p1;
    logic [7:0]        wait_cnt;
    logic [3:0]        flush_cnt;
    logic [RCNT_W-1:0] retire_cnt_r;
    logic              retire_w;
    logic              pc_load_w;
    logic              mem_req_w;

    assign dec    = decode(bus.instr);
    assign accept = bus.instr_valid && (state == S_IDLE);

    // ---- accept stage: capture operand and class ----
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= bus.instr[4:0];
            cls_p1  <= dec[2:0];
        end
    end

    // ---- control stage: state, wait/flush counters, retire counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            flush_cnt    <= '0;
            retire_cnt_r <= '0;
        end else begin
            state        <= state_n;
            wait_cnt     <= (state == S_MEM && !bus.mem_ack) ? wait_cnt + 8'd1 : 8'd0;
            flush_cnt    <= (state == S_FLUSH) ? flush_cnt + 4'd1 : 4'd0;
            if (retire_w)
                retire_cnt_r <= sat_inc(retire_cnt_r);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec[3])
                        state_n = S_ERR;
                    else if (dec[2:0] == 3'd0 || dec[2:0] == 3'd1)
                        state_n = S_MEM;
                    else if (dec[2:0] == 3'd2 || (dec[2:0] == 3'd3 && bus.branch_cond))
                        state_n = S_FLUSH;
                    else
                        state_n = S_RET;
                end
            end
            S_MEM: begin
                // An ack on the final wait cycle still completes normally.
                if (bus.mem_ack)
                    state_n = S_RET;
                else if (wait_cnt == WAIT_LAST)
                    state_n = S_ERR;
            end
            S_RET:   state_n = S_IDLE;
            // One redirect cycle followed by FLUSH_CYCLES bubbles.
            S_FLUSH: if (flush_cnt == FLUSH_LAST) state_n = S_IDLE;
            S_ERR:   if (bus.err_clr) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decode the asynchronously reset state, so reset drops them at once.
    assign mem_req_w = (state == S_MEM);
    assign pc_load_w = (state == S_FLUSH) && (flush_cnt == 4'd0);
    assign retire_w  = (state == S_RET) || pc_load_w;

    assign bus.instr_ready  = (state == S_IDLE);
    assign bus.mem_req      = mem_req_w;
    assign bus.mem_we       = mem_req_w && (cls_p1 == 3'd1);
    assign bus.mem_addr     = mem_req_w ? addr_p1 : 5'd0;
    assign bus.pc_load      = pc_load_w;
    assign bus.pc_target    = pc_load_w ? addr_p1 : 5'd0;
    assign bus.retire       = retire_w;
    assign bus.retire_class = retire_w ? cls_p1 : 3'd0;
    assign bus.illegal_err  = (state == S_ERR);
    assign bus.retire_cnt   = retire_cnt_r;
endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Scoreboard bench for instr_issue_sequencer: expected retire classes and redirect
// targets are queued at issue time and matched as the sequencer produces them.
module tb_instr_issue_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_issue_sequencer_if #(.RCNT_W(16)) bus ();

    instr_issue_sequencer #(
        .TIMEOUT     (15),
        .FLUSH_CYCLES(2),
        .RCNT_W      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];
    logic [4:0] tgt_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Retire/redirect scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.retire) begin
                if (exp_q.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
                else                   chk("retire_class", bus.retire_class, exp_q.pop_front());
            end
            if (bus.pc_load) begin
                if (tgt_q.size() == 0) chk("unexpected_pc_load", 32'd1, 32'd0);
                else                   chk("pc_target", bus.pc_target, tgt_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready)
            assert (!$isunknown(bus.instr)) else $error("protocol: unknown instr at accept");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [7:0] op, input logic cond);
        @(negedge clk);
        chk("ready_before_issue", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = op;
        bus.branch_cond = cond;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        bus.branch_cond = 1'b0;
    endtask

    // Counts cycles with instr_ready low; records pc_load/retire of the first one.
    task automatic count_busy(output int n, output logic pl1, output logic rt1);
        n = 0; pl1 = 1'b0; rt1 = 1'b0;
        @(negedge clk);
        while (!bus.instr_ready && n < 40) begin
            n++;
            if (n == 1) begin
                pl1 = bus.pc_load;
                rt1 = bus.retire;
            end
            @(negedge clk);
        end
        if (n >= 40) chk("busy_bound_expired", 32'd0, 32'd1);
    endtask

    // Acks in the n-th mem_req cycle, then checks the retire cycle.
    task automatic mem_ack_at(input int n, input logic we, input logic [4:0] addr);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk("mem_req_held", bus.mem_req, 1);
            chk("mem_we", bus.mem_we, we);
            chk("mem_addr", bus.mem_addr, addr);
            if (i == n) bus.mem_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("mem_retire", bus.retire, 1);
        chk("mem_no_err", bus.illegal_err, 0);
        chk("mem_req_after_ack", bus.mem_req, 0);
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared", bus.illegal_err, 0);
        chk("ready_after_clr", bus.instr_ready, 1);
    endtask

    initial begin
        int   n;
        logic pl1, rt1;
        logic [7:0] misc_ops[4];
        logic [7:0] bad_ops[2];
        misc_ops = '{8'hF8, 8'hF9, 8'hFA, 8'hFB};
        bad_ops  = '{8'h84, 8'hFF};

        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        bus.branch_cond = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.err_clr     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_retire", bus.retire, 0);
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_err", bus.illegal_err, 0);
        chk("rst_cnt", bus.retire_cnt, 0);
        rst_n = 1'b1;

        // LOAD, ack three cycles after mem_req rises
        exp_q.push_back(3'd0);
        issue(8'b00010101, 1'b0);
        mem_ack_at(4, 1'b0, 5'h15);

        // Stray ack while idle
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_ready", bus.instr_ready, 1);
        chk("stray_ack_mem_req", bus.mem_req, 0);
        chk("stray_ack_retire", bus.retire, 0);
        chk("cnt_after_load", bus.retire_cnt, 1);

        // STORE that is never acked
        issue(8'b00111111, 1'b0);
        @(negedge clk);
        chk("store_we", bus.mem_we, 1);
        chk("store_addr", bus.mem_addr, 5'h1F);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("store_timeout_cycles", n, 15);
        chk("timeout_err", bus.illegal_err, 1);
        chk("timeout_mem_req", bus.mem_req, 0);
        chk("timeout_ready", bus.instr_ready, 0);
        chk("timeout_no_retire", bus.retire, 0);
        clear_err();
        chk("cnt_after_timeout", bus.retire_cnt, 1);

        // Ack arriving on the final wait cycle wins over the timeout
        exp_q.push_back(3'd0);
        issue(8'b00000000, 1'b0);
        mem_ack_at(15, 1'b0, 5'h00);

        // JUMP: redirect plus two bubbles
        exp_q.push_back(3'd2);
        tgt_q.push_back(5'h0A);
        issue(8'b01001010, 1'b0);
        count_busy(n, pl1, rt1);
        chk("jump_busy_cycles", n, 3);
        chk("jump_pc_load", pl1, 1);
        chk("jump_retire", rt1, 1);

        // Taken branch
        exp_q.push_back(3'd3);
        tgt_q.push_back(5'h03);
        issue(8'b01100011, 1'b1);
        count_busy(n, pl1, rt1);
        chk("br_taken_busy", n, 3);
        chk("br_taken_pc_load", pl1, 1);

        // Not-taken branch
        exp_q.push_back(3'd3);
        issue(8'b01100011, 1'b0);
        count_busy(n, pl1, rt1);
        chk("br_nt_busy", n, 1);
        chk("br_nt_pc_load", pl1, 0);
        chk("br_nt_retire", rt1, 1);

        // Misc classes 4..7
        foreach (misc_ops[i]) begin
            exp_q.push_back(3'(4 + i));
            issue(misc_ops[i], 1'b0);
            count_busy(n, pl1, rt1);
            chk("misc_busy", n, 1);
            chk("misc_retire", rt1, 1);
        end
        chk("cnt_after_misc", bus.retire_cnt, 9);

        // Illegal encodings
        foreach (bad_ops[i]) begin
            issue(bad_ops[i], 1'b0);
            @(negedge clk);
            chk("illegal_err", bus.illegal_err, 1);
            chk("illegal_no_retire", bus.retire, 0);
            chk("illegal_ready", bus.instr_ready, 0);
            clear_err();
        end
        chk("cnt_after_illegal", bus.retire_cnt, 9);

        // Retire counter saturation
        @(negedge clk);
        force dut.retire_cnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.retire_cnt_r;
        chk("cnt_forced", bus.retire_cnt, 16'hFFFF);
        exp_q.push_back(3'd4);
        issue(8'hF8, 1'b0);
        count_busy(n, pl1, rt1);
        chk("cnt_saturated", bus.retire_cnt, 16'hFFFF);

        // Reset in the middle of a memory request
        issue(8'b00010101, 1'b0);
        @(negedge clk);
        chk("pre_reset_mem_req", bus.mem_req, 1);
        #1 rst_n = 1'b0;
        #1 chk("mem_req_async_drop", bus.mem_req, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.instr_ready, 1);
        chk("post_rst_cnt", bus.retire_cnt, 0);
        chk("post_rst_mem_req", bus.mem_req, 0);
        chk("post_rst_retire", bus.retire, 0);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", exp_q.size() + tgt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
